mem_copy_engine: RTL

Sequential memory initiator that copies a block of bytes from one region of `dataMemory` to another, one byte at a time. It is the bus-master end of the `dataMemory` port: it drives `address`, `data` and `memWrite`, and consumes `out`. Software-visible control is a start/busy/done handshake, and the block keeps a running 8-bit checksum of the bytes it moves. It sits beside the datapath and shares the memory port through the top-level mux, which selects it while `busy` is high.

---
 rtl/mem_copy_pkg.sv | 15 +
 rtl/mem_copy_engine_if.sv | 32 +++
 rtl/mem_copy_engine.sv | 94 +++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types for the byte-serial memory copy engine.
// State encoding and default bus widths.
package mem_copy_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Control handshake and dataMemory bus of the copy engine.
// master = engine side, slave = system/memory side.
interface mem_copy_engine_if
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          start;
  logic [AW-1:0] srcAddr;
  logic [AW-1:0] dstAddr;
  logic [AW-1:0] length;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic          memWrite;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic [DW-1:0] memOut;

  modport master (
    input  start, srcAddr, dstAddr, length, memOut,
    output busy, done, checksum, memWrite, address, data
  );

  modport slave (
    output start, srcAddr, dstAddr, length, memOut,
    input  busy, done, checksum, memWrite, address, data
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Byte-serial forward copy between two dataMemory regions.
// READ/WRITE alternate per byte; keeps a running mod-256 checksum.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic                clock,
  input logic                reset,
  mem_copy_engine_if.master  bus
);

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] len;
  logic [AW-1:0] idx;
  logic [DW-1:0] holdBuf;
  logic [DW-1:0] sum;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start)
          nxt = (bus.length == '0) ? DONE : READ;
      end
      READ:  nxt = WRITE;
      WRITE: nxt = (idx + AW'(1) == len) ? DONE : READ;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // latched parameters, byte index, holding buffer, checksum
  always_ff @(posedge clock) begin
    if (reset) begin
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      idx     <= '0;
      holdBuf <= '0;
      sum     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            src <= bus.srcAddr;
            dst <= bus.dstAddr;
            len <= bus.length;
            idx <= '0;
            sum <= '0;
          end
        end
        READ: begin
          holdBuf <= bus.memOut;
          sum     <= sum + bus.memOut;
        end
        WRITE:   idx <= idx + AW'(1);
        default: ;
      endcase
    end
  end

  // bus outputs; reset blocks the write committing on its own edge
  always_comb begin
    bus.address  = '0;
    bus.data     = '0;
    bus.memWrite = 1'b0;
    unique case (state)
      READ: bus.address = src + idx;
      WRITE: begin
        bus.address  = dst + idx;
        bus.data     = holdBuf;
        bus.memWrite = ~reset;
      end
      default: ;
    endcase
  end

  assign bus.busy     = (state == READ) || (state == WRITE);
  assign bus.done     = (state == DONE);
  assign bus.checksum = sum;

endmodule
